dmac_ch_reg_bank: RTL and testbench

//  Parametrised multi-channel DMAC register bank: AHB-slave-programmable register file plus per-channel

---
 rtl/dmac_ch_reg_bank.sv | 236 +++++++++++++++++++++++
 tb/tb_dmac_ch_reg_bank.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_ch_reg_bank.sv
// dmac_ch_reg_bank
// AHB-programmable register file for an N-channel DMAC plus the working
// state (pointers, burst beat counters, remaining size, interrupt status)
// that the master engine steps through while moving data for ch_sel.
module dmac_ch_reg_bank #(
  parameter  int NUM_CH = 2,
  parameter  int TS_W   = 12,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              r_HCLK,
  input  logic              HRESETn,
  input  logic [31:0]       r_HADDR,
  input  logic [31:0]       r_HWDATA,
  input  logic              load_ahb_addr,
  input  logic              write_out_reg,
  output logic [31:0]       r_HRDATA,
  input  logic              m_HGRANT,
  output logic              sync_grant,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              load_ch_addr,
  input  logic              src_addr_inc,
  input  logic              dest_addr_inc,
  input  logic              ts_dec,
  output logic [NUM_CH-1:0] ch_en,
  output logic [TS_W-1:0]   ts_cur,
  output logic [2:0]        bs_cur,
  output logic [31:0]       src_ptr,
  output logic [31:0]       dest_ptr,
  output logic              src_burst_done,
  output logic              dest_burst_done,
  output logic              DMACINTR
);

  // Host-visible registers
  logic [11:0]       r_addr_q;
  logic [31:0]       r_src_addr  [NUM_CH];
  logic [31:0]       r_dest_addr [NUM_CH];
  logic [2:0]        r_bs        [NUM_CH];
  logic [TS_W-1:0]   r_ts        [NUM_CH];
  logic [NUM_CH-1:0] r_mask;
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_raw_int;
  logic              r_global_en;

  // Engine working state
  logic [31:0]       r_src_ptr;
  logic [31:0]       r_dest_ptr;
  logic [6:0]        r_src_cnt;
  logic [6:0]        r_dest_cnt;
  logic              r_sync_grant;

  // Address decode (channel block lives at 0x100..0x1FF, stride 0x20)
  logic              w_ch_hit;
  logic [2:0]        w_ch_idx;
  logic [4:0]        w_ch_off;
  logic              w_wr_intclr;
  logic              w_wr_config;
  logic [NUM_CH-1:0] w_wr_src;
  logic [NUM_CH-1:0] w_wr_dest;
  logic [NUM_CH-1:0] w_wr_ctl;
  logic [NUM_CH-1:0] w_wr_cfg;

  // Selected-channel view for the master engine
  logic [NUM_CH-1:0] w_sel_oh;
  logic [TS_W-1:0]   w_ts_sel;
  logic [2:0]        w_bs_sel;
  logic [31:0]       w_src_sel;
  logic [31:0]       w_dest_sel;
  logic [TS_W-1:0]   w_ts_next;
  logic              w_ts_done;
  logic [7:0]        w_beats_m1;
  logic [NUM_CH-1:0] w_int_clr;
  logic [NUM_CH-1:0] w_int_set;
  logic [31:0]       w_rdata;

  assign w_ch_idx    = r_addr_q[7:5];
  assign w_ch_off    = r_addr_q[4:0];
  assign w_ch_hit    = (r_addr_q[11:8] == 4'h1) && ({29'd0, w_ch_idx} < NUM_CH);
  assign w_wr_intclr = write_out_reg && (r_addr_q == 12'h008);
  assign w_wr_config = write_out_reg && (r_addr_q == 12'h030);

  // Per-channel write strobes and the ch_sel mux
  // NOTE: every output of an always_comb gets a default first, so no path can leave it holding a stale value (a latch).
  always_comb begin
    w_wr_src   = '0;
    w_wr_dest  = '0;
    w_wr_ctl   = '0;
    w_wr_cfg   = '0;
    w_sel_oh   = '0;
    w_ts_sel   = '0;
    w_bs_sel   = '0;
    w_src_sel  = '0;
    w_dest_sel = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (write_out_reg && w_ch_hit && (w_ch_idx == 3'(n))) begin
        w_wr_src[n]  = (w_ch_off == 5'h00);
        w_wr_dest[n] = (w_ch_off == 5'h04);
        w_wr_ctl[n]  = (w_ch_off == 5'h0C);
        w_wr_cfg[n]  = (w_ch_off == 5'h10);
      end
      if (ch_sel == CH_W'(n)) begin
        w_sel_oh[n] = 1'b1;
        w_ts_sel    = r_ts[n];
        w_bs_sel    = r_bs[n];
        w_src_sel   = r_src_addr[n];
        w_dest_sel  = r_dest_addr[n];
      end
    end
  end

  // Size countdown saturates at 0; a host write to Control of the same
  // channel on the same edge overrides both the decrement and completion.
  assign w_ts_next  = (w_ts_sel > TS_W'(3)) ? (w_ts_sel - TS_W'(4)) : '0;
  assign w_ts_done  = ts_dec && (|w_sel_oh) && (w_ts_sel != '0) &&
                      (w_ts_next == '0) && !(|(w_wr_ctl & w_sel_oh));
  assign w_int_set  = w_ts_done ? w_sel_oh : '0;
  assign w_int_clr  = w_wr_intclr ? r_HWDATA[NUM_CH-1:0] : '0;

  assign w_beats_m1      = (8'd1 << w_bs_sel) - 8'd1;
  assign src_burst_done  = src_addr_inc  && !load_ch_addr && ({1'b0, r_src_cnt}  == w_beats_m1);
  assign dest_burst_done = dest_addr_inc && !load_ch_addr && ({1'b0, r_dest_cnt} == w_beats_m1);

  // Latched AHB address and registered grant
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge r_HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr_q     <= '0;
      r_sync_grant <= 1'b0;
    end else begin
      r_sync_grant <= m_HGRANT;
      if (load_ahb_addr) r_addr_q <= r_HADDR[11:0];
    end
  end

  // Per-channel programmable registers with engine-side updates
  // NOTE: the register arrays are reset element by element: they are software-visible and must read back 0 after reset.
  always_ff @(posedge r_HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_src_addr[n]  <= '0;
        r_dest_addr[n] <= '0;
        r_bs[n]        <= '0;
        r_ts[n]        <= '0;
      end
      r_mask <= '0;
      r_en   <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_wr_src[n])  r_src_addr[n]  <= r_HWDATA;
        if (w_wr_dest[n]) r_dest_addr[n] <= r_HWDATA;
        if (w_wr_ctl[n]) begin
          r_bs[n] <= r_HWDATA[14:12];
          r_ts[n] <= r_HWDATA[TS_W-1:0];
        end else if (ts_dec && w_sel_oh[n]) begin
          r_ts[n] <= w_ts_next;
        end
        if (w_wr_cfg[n]) begin
          r_mask[n] <= r_HWDATA[1];
          r_en[n]   <= r_HWDATA[0];
        end else if (w_int_set[n]) begin
          r_en[n]   <= 1'b0;
        end
      end
    end
  end

  // Global enable and raw interrupt status (completion wins over W1C)
  always_ff @(posedge r_HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_global_en <= 1'b0;
      r_raw_int   <= '0;
    end else begin
      if (w_wr_config) r_global_en <= r_HWDATA[0];
      r_raw_int <= (r_raw_int & ~w_int_clr) | w_int_set;
    end
  end

  // Working pointers and burst beat counters
  always_ff @(posedge r_HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_src_ptr  <= '0;
      r_dest_ptr <= '0;
      r_src_cnt  <= '0;
      r_dest_cnt <= '0;
    end else if (load_ch_addr && (|w_sel_oh)) begin
      r_src_ptr  <= {w_src_sel[31:2], 2'b00};
      r_dest_ptr <= {w_dest_sel[31:2], 2'b00};
      r_src_cnt  <= '0;
      r_dest_cnt <= '0;
    end else begin
      if (src_addr_inc) begin
        r_src_ptr <= r_src_ptr + 32'd4;
        r_src_cnt <= src_burst_done ? 7'd0 : r_src_cnt + 7'd1;
      end
      if (dest_addr_inc) begin
        r_dest_ptr <= r_dest_ptr + 32'd4;
        r_dest_cnt <= dest_burst_done ? 7'd0 : r_dest_cnt + 7'd1;
      end
    end
  end

  // Readback mux from the latched address; unmapped reads return 0
  always_comb begin
    w_rdata = '0;
    if (r_addr_q == 12'h004) begin
      w_rdata[NUM_CH-1:0] = r_raw_int;
    end else if (r_addr_q == 12'h030) begin
      w_rdata[0] = r_global_en;
    end else if (w_ch_hit) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_ch_idx == 3'(n)) begin
          case (w_ch_off)
            5'h00: w_rdata = r_src_addr[n];
            5'h04: w_rdata = r_dest_addr[n];
            5'h0C: begin
              w_rdata[14:12]     = r_bs[n];
              w_rdata[TS_W-1:0]  = r_ts[n];
            end
            5'h10: w_rdata[1:0] = {r_mask[n], r_en[n]};
            default: ;
          endcase
        end
      end
    end
  end

  assign r_HRDATA   = w_rdata;
  assign sync_grant = r_sync_grant;
  assign ch_en      = r_en & {NUM_CH{r_global_en}};
  assign ts_cur     = w_ts_sel;
  assign bs_cur     = w_bs_sel;
  assign src_ptr    = r_src_ptr;
  assign dest_ptr   = r_dest_ptr;
  assign DMACINTR   = |(r_raw_int & ~r_mask);

endmodule

// File: tb/tb_dmac_ch_reg_bank.sv
// tb_dmac_ch_reg_bank
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural register-bank model held in plain arrays.
module tb_dmac_ch_reg_bank;
  localparam int NUM_CH = 2;
  localparam int TS_W   = 12;

  logic              r_HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic [31:0]       r_HADDR = '0;
  logic [31:0]       r_HWDATA = '0;
  logic              load_ahb_addr = 1'b0;
  logic              write_out_reg = 1'b0;
  logic [31:0]       r_HRDATA;
  logic              m_HGRANT = 1'b0;
  logic              sync_grant;
  logic [0:0]        ch_sel = '0;
  logic              load_ch_addr = 1'b0;
  logic              src_addr_inc = 1'b0;
  logic              dest_addr_inc = 1'b0;
  logic              ts_dec = 1'b0;
  logic [NUM_CH-1:0] ch_en;
  logic [TS_W-1:0]   ts_cur;
  logic [2:0]        bs_cur;
  logic [31:0]       src_ptr;
  logic [31:0]       dest_ptr;
  logic              src_burst_done;
  logic              dest_burst_done;
  logic              DMACINTR;

  always #5 r_HCLK = ~r_HCLK;

  dmac_ch_reg_bank #(.NUM_CH(NUM_CH), .TS_W(TS_W)) dut (
    .r_HCLK(r_HCLK), .HRESETn(HRESETn), .r_HADDR(r_HADDR), .r_HWDATA(r_HWDATA),
    .load_ahb_addr(load_ahb_addr), .write_out_reg(write_out_reg), .r_HRDATA(r_HRDATA),
    .m_HGRANT(m_HGRANT), .sync_grant(sync_grant), .ch_sel(ch_sel),
    .load_ch_addr(load_ch_addr), .src_addr_inc(src_addr_inc), .dest_addr_inc(dest_addr_inc),
    .ts_dec(ts_dec), .ch_en(ch_en), .ts_cur(ts_cur), .bs_cur(bs_cur),
    .src_ptr(src_ptr), .dest_ptr(dest_ptr), .src_burst_done(src_burst_done),
    .dest_burst_done(dest_burst_done), .DMACINTR(DMACINTR)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model
  logic [31:0] m_src [NUM_CH];
  logic [31:0] m_dst [NUM_CH];
  int          m_bs  [NUM_CH];
  int          m_ts  [NUM_CH];
  bit          m_mask[NUM_CH];
  bit          m_en  [NUM_CH];
  bit          m_raw [NUM_CH];
  bit          m_gen;
  logic [11:0] m_addr_q;
  logic [31:0] m_sptr, m_dptr;
  int          m_sbeat, m_dbeat;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_src[i] = '0; m_dst[i] = '0; m_bs[i] = 0; m_ts[i] = 0;
      m_mask[i] = 0; m_en[i] = 0; m_raw[i] = 0;
    end
    m_gen = 0; m_addr_q = '0; m_sptr = '0; m_dptr = '0; m_sbeat = 0; m_dbeat = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    int ai, n, off;
    model_read = '0;
    ai = int'(a);
    if (ai == 'h004) begin
      for (int i = 0; i < NUM_CH; i++) model_read[i] = m_raw[i];
    end else if (ai == 'h030) begin
      model_read[0] = m_gen;
    end else if (ai >= 'h100 && ai < 'h100 + 32 * NUM_CH) begin
      n = (ai - 'h100) / 32;
      off = (ai - 'h100) % 32;
      case (off)
        0:  model_read = m_src[n];
        4:  model_read = m_dst[n];
        12: model_read = 32'(m_bs[n] * 4096 + m_ts[n]);
        16: model_read = 32'(m_mask[n] * 2 + m_en[n]);
        default: model_read = '0;
      endcase
    end
  endfunction

  function automatic logic [NUM_CH-1:0] exp_ch_en();
    exp_ch_en = '0;
    for (int i = 0; i < NUM_CH; i++) exp_ch_en[i] = m_en[i] && m_gen;
  endfunction

  function automatic logic exp_intr();
    exp_intr = 1'b0;
    for (int i = 0; i < NUM_CH; i++) if (m_raw[i] && !m_mask[i]) exp_intr = 1'b1;
  endfunction

  // Latch an address (one cycle, no other activity); starts and ends on a falling edge
  task automatic set_addr(input logic [31:0] a);
    r_HADDR = a;
    load_ahb_addr = 1'b1;
    @(negedge r_HCLK);
    load_ahb_addr = 1'b0;
    m_addr_q = a[11:0];
  endtask

  // One clock of engine/host activity; returns observed and predicted burst pulses
  task automatic cycle(input bit wr, input logic [31:0] wd, input bit dec, input bit sinc,
                       input bit dinc, input bit lch,
                       output bit s_obs, output bit d_obs, output bit s_exp, output bit d_exp);
    int sel, beats, a, n, off;
    bit done, ctl_hit, cfg_hit;
    sel = int'(ch_sel);
    write_out_reg = wr; r_HWDATA = wd; ts_dec = dec;
    src_addr_inc = sinc; dest_addr_inc = dinc; load_ch_addr = lch;
    #1;
    s_obs = src_burst_done;
    d_obs = dest_burst_done;
    beats = 1 << m_bs[sel];
    s_exp = sinc && !lch && (m_sbeat == beats - 1);
    d_exp = dinc && !lch && (m_dbeat == beats - 1);
    // engine side, from pre-edge register contents
    if (lch) begin
      m_sptr = m_src[sel] & 32'hFFFF_FFFC;
      m_dptr = m_dst[sel] & 32'hFFFF_FFFC;
      m_sbeat = 0; m_dbeat = 0;
    end else begin
      if (sinc) begin m_sptr = m_sptr + 32'd4; m_sbeat = s_exp ? 0 : m_sbeat + 1; end
      if (dinc) begin m_dptr = m_dptr + 32'd4; m_dbeat = d_exp ? 0 : m_dbeat + 1; end
    end
    done = 0;
    if (dec && m_ts[sel] != 0) begin
      m_ts[sel] = (m_ts[sel] >= 4) ? m_ts[sel] - 4 : 0;
      done = (m_ts[sel] == 0);
    end
    // host side overrides the engine on the same register
    ctl_hit = 0; cfg_hit = 0;
    a = int'(m_addr_q);
    if (wr) begin
      if (a == 'h008) begin
        for (int i = 0; i < NUM_CH; i++) if (wd[i]) m_raw[i] = 0;
      end else if (a == 'h030) begin
        m_gen = wd[0];
      end else if (a >= 'h100 && a < 'h100 + 32 * NUM_CH) begin
        n = (a - 'h100) / 32;
        off = (a - 'h100) % 32;
        case (off)
          0:  m_src[n] = wd;
          4:  m_dst[n] = wd;
          12: begin m_bs[n] = int'(wd[14:12]); m_ts[n] = int'(wd[11:0]); ctl_hit = (n == sel); end
          16: begin m_mask[n] = wd[1]; m_en[n] = wd[0]; cfg_hit = (n == sel); end
          default: ;
        endcase
      end
    end
    if (done && !ctl_hit) begin
      m_raw[sel] = 1;
      if (!cfg_hit) m_en[sel] = 0;
    end
    @(negedge r_HCLK);
    write_out_reg = 1'b0; ts_dec = 1'b0; src_addr_inc = 1'b0;
    dest_addr_inc = 1'b0; load_ch_addr = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bit so, dd, se, de;
    set_addr(a);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, so, dd, se, de);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    set_addr(a);
    d = r_HRDATA;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [11] = '{32'h004, 32'h008, 32'h030, 32'h100, 32'h104, 32'h10C,
                                32'h110, 32'h120, 32'h124, 32'h12C, 32'h130};
    logic [31:0] d;
    HRESETn = 1'b0;
    model_reset();
    repeat (2) @(negedge r_HCLK);
    n_vec++; if (ch_en !== '0) begin n_err++; $display("FAIL reset_ch_en: got %h expected 0", ch_en); end
    n_vec++; if (ts_cur !== '0 || bs_cur !== '0) begin n_err++; $display("FAIL reset_ts_bs: got %h/%h expected 0/0", ts_cur, bs_cur); end
    n_vec++; if (src_ptr !== '0 || dest_ptr !== '0) begin n_err++; $display("FAIL reset_ptrs: got %h/%h expected 0/0", src_ptr, dest_ptr); end
    n_vec++; if ({src_burst_done, dest_burst_done, DMACINTR, sync_grant} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0000", {src_burst_done, dest_burst_done, DMACINTR, sync_grant}); end
    n_vec++; if (r_HRDATA !== '0) begin n_err++; $display("FAIL reset_hrdata: got %h expected 0", r_HRDATA); end
    HRESETn = 1'b1;
    @(negedge r_HCLK);
    foreach (addrs[i]) begin
      rd(addrs[i], d);
      n_vec++; if (d !== '0) begin n_err++; $display("FAIL reset_read[%h]: got %h expected 0", addrs[i], d); end
    end
  endtask

  task automatic test_program();
    logic [31:0] d;
    wr(32'h100, 32'h2003);
    wr(32'h104, 32'h3000);
    wr(32'h10C, 32'h1010);
    wr(32'h110, 32'h1);
    n_vec++; if (ch_en !== 2'b00) begin n_err++; $display("FAIL global_off_ch_en: got %b expected 00", ch_en); end
    wr(32'h030, 32'h1);
    rd(32'h100, d); n_vec++; if (d !== 32'h2003) begin n_err++; $display("FAIL rd_src: got %h expected 00002003", d); end
    rd(32'h104, d); n_vec++; if (d !== 32'h3000) begin n_err++; $display("FAIL rd_dest: got %h expected 00003000", d); end
    rd(32'h10C, d); n_vec++; if (d !== 32'h1010) begin n_err++; $display("FAIL rd_ctl: got %h expected 00001010", d); end
    rd(32'h110, d); n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL rd_cfg: got %h expected 00000001", d); end
    rd(32'h030, d); n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL rd_config: got %h expected 00000001", d); end
    n_vec++; if (ch_en !== 2'b01) begin n_err++; $display("FAIL prog_ch_en: got %b expected 01", ch_en); end
  endtask

  task automatic test_pointers();
    bit so, dd, se, de;
    ch_sel = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, so, dd, se, de);
    n_vec++; if (src_ptr !== 32'h2000 || dest_ptr !== 32'h3000) begin
      n_err++; $display("FAIL load_ptrs: got %h/%h expected 00002000/00003000", src_ptr, dest_ptr); end
    n_vec++; if (bs_cur !== 3'd1 || ts_cur !== 12'h010) begin
      n_err++; $display("FAIL sel_view: got bs=%0d ts=%h expected bs=1 ts=010", bs_cur, ts_cur); end
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, so, dd, se, de);
    n_vec++; if (so !== 1'b0) begin n_err++; $display("FAIL burst_beat1: got %b expected 0", so); end
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, so, dd, se, de);
    n_vec++; if (so !== 1'b1) begin n_err++; $display("FAIL burst_beat2: got %b expected 1", so); end
    n_vec++; if (src_ptr !== 32'h2008) begin n_err++; $display("FAIL src_ptr_step: got %h expected 00002008", src_ptr); end
  endtask

  task automatic test_complete();
    bit so, dd, se, de;
    logic [31:0] d;
    ch_sel = 1'b0;
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, so, dd, se, de);
    n_vec++; if (ts_cur !== 12'h004 || ch_en !== 2'b01 || DMACINTR !== 1'b0) begin
      n_err++; $display("FAIL ts_3dec: got ts=%h en=%b int=%b expected 004/01/0", ts_cur, ch_en, DMACINTR); end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, so, dd, se, de);
    n_vec++; if (ts_cur !== '0 || ch_en !== 2'b00 || DMACINTR !== 1'b1) begin
      n_err++; $display("FAIL ts_done: got ts=%h en=%b int=%b expected 000/00/1", ts_cur, ch_en, DMACINTR); end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, so, dd, se, de);
    n_vec++; if (ts_cur !== '0) begin n_err++; $display("FAIL ts_floor: got %h expected 000", ts_cur); end
    rd(32'h004, d); n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL raw_int: got %h expected 00000001", d); end
    wr(32'h008, 32'h1);
    n_vec++; if (DMACINTR !== 1'b0) begin n_err++; $display("FAIL int_clear: got %b expected 0", DMACINTR); end
  endtask

  task automatic test_collision();
    bit so, dd, se, de;
    logic [31:0] addrs [8] = '{32'h004, 32'h030, 32'h100, 32'h104, 32'h10C, 32'h110, 32'h120, 32'h12C};
    logic [31:0] d;
    ch_sel = 1'b0;
    wr(32'h10C, 32'h010);
    set_addr(32'h10C);
    cycle(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, so, dd, se, de);
    n_vec++; if (ts_cur !== 12'h040) begin n_err++; $display("FAIL ctl_beats_dec: got %h expected 040", ts_cur); end
    wr(32'h0FC, 32'hFFFF_FFFF);
    wr(32'h140, 32'hFFFF_FFFF);
    wr(32'h14C, 32'hFFFF_FFFF);
    foreach (addrs[i]) begin
      rd(addrs[i], d);
      n_vec++; if (d !== model_read(addrs[i][11:0])) begin
        n_err++; $display("FAIL unmapped_wr[%h]: got %h expected %h", addrs[i], d, model_read(addrs[i][11:0])); end
    end
  endtask

  task automatic test_clear_race();
    bit so, dd, se, de;
    logic [31:0] d;
    ch_sel = 1'b0;
    wr(32'h10C, 32'h004);
    wr(32'h110, 32'h1);
    set_addr(32'h008);
    cycle(1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, so, dd, se, de);
    n_vec++; if (DMACINTR !== 1'b1) begin n_err++; $display("FAIL set_beats_clear: got %b expected 1", DMACINTR); end
    wr(32'h110, 32'h2);
    n_vec++; if (DMACINTR !== 1'b0) begin n_err++; $display("FAIL mask_intr: got %b expected 0", DMACINTR); end
    rd(32'h004, d); n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL mask_raw: got %h expected 00000001", d); end
  endtask

  task automatic test_wrap();
    bit so, dd, se, de;
    wr(32'h120, 32'hFFFF_FFFF);
    wr(32'h124, 32'hFFFF_FFF8);
    ch_sel = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, so, dd, se, de);
    n_vec++; if (src_ptr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL align_load: got %h expected fffffffc", src_ptr); end
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, so, dd, se, de);
    n_vec++; if (src_ptr !== 32'h0 || dest_ptr !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL ptr_wrap: got %h/%h expected 00000000/fffffffc", src_ptr, dest_ptr); end
    n_vec++; if (so !== 1'b1 || dd !== 1'b1) begin n_err++; $display("FAIL bs0_done: got %b%b expected 11", so, dd); end
  endtask

  task automatic test_grant();
    bit prev, g;
    prev = sync_grant;
    for (int i = 0; i < 12; i++) begin
      g = 1'($urandom);
      m_HGRANT = g;
      #1;
      n_vec++; if (sync_grant !== prev) begin n_err++; $display("FAIL grant_hold: got %b expected %b", sync_grant, prev); end
      @(negedge r_HCLK);
      n_vec++; if (sync_grant !== g) begin n_err++; $display("FAIL grant_sync: got %b expected %b", sync_grant, g); end
      prev = g;
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [14] = '{32'h004, 32'h008, 32'h030, 32'h100, 32'h104, 32'h10C, 32'h110,
                               32'h120, 32'h124, 32'h12C, 32'h130, 32'h0FC, 32'h140, 32'h108};
    bit so, dd, se, de;
    logic [31:0] wd;
    for (int it = 0; it < 400; it++) begin
      ch_sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) set_addr(pool[$urandom_range(0, 13)]);
      if (m_addr_q[4:0] == 5'h0C)      wd = (32'($urandom_range(0, 2)) << 12) | 32'($urandom_range(0, 40));
      else if (m_addr_q[4:0] == 5'h10) wd = 32'($urandom_range(0, 3));
      else                             wd = $urandom;
      cycle($urandom_range(0, 2) == 0, wd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, so, dd, se, de);
      n_vec++; if (so !== se || dd !== de) begin n_err++; $display("FAIL rnd_burst[%0d]: got %b%b expected %b%b", it, so, dd, se, de); end
      n_vec++; if (ts_cur !== 12'(m_ts[ch_sel]) || bs_cur !== 3'(m_bs[ch_sel])) begin
        n_err++; $display("FAIL rnd_sel[%0d]: got ts=%h bs=%0d expected ts=%h bs=%0d", it, ts_cur, bs_cur, m_ts[ch_sel], m_bs[ch_sel]); end
      n_vec++; if (src_ptr !== m_sptr || dest_ptr !== m_dptr) begin
        n_err++; $display("FAIL rnd_ptr[%0d]: got %h/%h expected %h/%h", it, src_ptr, dest_ptr, m_sptr, m_dptr); end
      n_vec++; if (ch_en !== exp_ch_en() || DMACINTR !== exp_intr()) begin
        n_err++; $display("FAIL rnd_en_int[%0d]: got %b/%b expected %b/%b", it, ch_en, DMACINTR, exp_ch_en(), exp_intr()); end
      n_vec++; if (r_HRDATA !== model_read(m_addr_q)) begin
        n_err++; $display("FAIL rnd_read[%0d] @%h: got %h expected %h", it, m_addr_q, r_HRDATA, model_read(m_addr_q)); end
    end
  endtask

  task automatic test_async_reset();
    bit so, dd, se, de;
    logic [31:0] d;
    wr(32'h100, 32'h5550);
    wr(32'h10C, 32'h1008);
    wr(32'h110, 32'h1);
    wr(32'h030, 32'h1);
    ch_sel = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, so, dd, se, de);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, so, dd, se, de);
    n_vec++; if (src_ptr !== 32'h5554 || ts_cur !== 12'h004 || ch_en !== 2'b01) begin
      n_err++; $display("FAIL pre_reset: got %h/%h/%b expected 00005554/004/01", src_ptr, ts_cur, ch_en); end
    #2 HRESETn = 1'b0;
    #1;
    n_vec++; if (src_ptr !== '0 || ts_cur !== '0 || ch_en !== '0 || DMACINTR !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got %h/%h/%b/%b expected all 0", src_ptr, ts_cur, ch_en, DMACINTR); end
    @(negedge r_HCLK);
    HRESETn = 1'b1;
    model_reset();
    rd(32'h100, d);
    n_vec++; if (d !== '0) begin n_err++; $display("FAIL post_reset_read: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_pointers();
    test_complete();
    test_collision();
    test_clear_race();
    test_wrap();
    test_grant();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
